// File: rtl/seq_scheduler_if.sv
// rtl/seq_scheduler_if.sv - generator control bus and term output stream of the sequence scheduler
interface seq_scheduler_if #(
    parameter int NUM_SEQ = 8
);
    logic [8*NUM_SEQ-1:0] gen_data;
    logic [NUM_SEQ-1:0]   gen_clear;
    logic [NUM_SEQ-1:0]   gen_step;
    logic [7:0]           out_data;
    logic [2:0]           out_seq;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  gen_data,
        input  out_ready,
        output gen_clear,
        output gen_step,
        output out_data,
        output out_seq,
        output out_last,
        output out_valid
    );

    modport slave (
        output gen_data,
        output out_ready,
        input  gen_clear,
        input  gen_step,
        input  out_data,
        input  out_seq,
        input  out_last,
        input  out_valid
    );
endinterface

// File: rtl/seq_scheduler.sv
// rtl/seq_scheduler.sv - restarts, steps and drains up to eight term generators onto one output stream
module seq_scheduler #(
    parameter int NUM_SEQ = 8,
    parameter int TERM_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [2:0]        sel,
    input  logic [TERM_W-1:0] term_count,
    seq_scheduler_if.master   bus,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        PRESENT,
        STEP,
        DONE
    } state_t;

    localparam logic [TERM_W:0]    ONE_TERM   = (TERM_W+1)'(1);
    localparam logic [TERM_W:0]    FULL_COUNT = {1'b1, {TERM_W{1'b0}}};
    localparam logic [2:0]         LAST_ID    = 3'(NUM_SEQ-1);
    localparam logic [NUM_SEQ-1:0] LANE0      = NUM_SEQ'(1);

    state_t              state, state_nxt;
    logic [2:0]          cur, cur_nxt;
    logic [TERM_W:0]     remaining, remaining_nxt;
    logic [TERM_W:0]     count_lat, count_lat_nxt;
    logic                mode_lat, mode_lat_nxt;
    logic [7:0]          data_q, data_nxt;
    logic [2:0]          seq_q, seq_nxt;
    logic                last_q, last_nxt;
    logic [NUM_SEQ-1:0]  clear_q, clear_nxt;
    logic [NUM_SEQ-1:0]  step_q, step_nxt;
    logic [TERM_W:0]     load_count;

    // A programmed count of zero means the full 2**TERM_W terms.
    assign load_count = (term_count == '0) ? FULL_COUNT : {1'b0, term_count};

    always_comb begin
        state_nxt     = state;
        cur_nxt       = cur;
        remaining_nxt = remaining;
        count_lat_nxt = count_lat;
        mode_lat_nxt  = mode_lat;
        data_nxt      = data_q;
        seq_nxt       = seq_q;
        last_nxt      = last_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = CLEAR;
                    cur_nxt       = mode ? 3'd0 : sel;
                    remaining_nxt = load_count;
                    count_lat_nxt = load_count;
                    mode_lat_nxt  = mode;
                end
            end
            CLEAR: state_nxt = LOAD;
            LOAD: begin
                data_nxt  = bus.gen_data[{cur, 3'b000} +: 8];
                seq_nxt   = cur;
                last_nxt  = (remaining == ONE_TERM);
                state_nxt = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    if (remaining > ONE_TERM) begin
                        remaining_nxt = remaining - ONE_TERM;
                        state_nxt     = STEP;
                    end else if (mode_lat && (cur != LAST_ID)) begin
                        cur_nxt       = cur + 3'd1;
                        remaining_nxt = count_lat;
                        state_nxt     = CLEAR;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            STEP:    state_nxt = LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort wins over everything, including a transfer on the same edge.
        if ((state != IDLE) && abort) begin
            state_nxt = IDLE;
        end

        // Pulses are registered from the next state so they line up with CLEAR/STEP.
        clear_nxt = (state_nxt == CLEAR) ? (LANE0 << cur_nxt) : '0;
        step_nxt  = (state_nxt == STEP)  ? (LANE0 << cur_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            remaining <= '0;
            count_lat <= '0;
            mode_lat  <= 1'b0;
            data_q    <= '0;
            seq_q     <= '0;
            last_q    <= 1'b0;
            clear_q   <= '0;
            step_q    <= '0;
        end else begin
            state     <= state_nxt;
            cur       <= cur_nxt;
            remaining <= remaining_nxt;
            count_lat <= count_lat_nxt;
            mode_lat  <= mode_lat_nxt;
            data_q    <= data_nxt;
            seq_q     <= seq_nxt;
            last_q    <= last_nxt;
            clear_q   <= clear_nxt;
            step_q    <= step_nxt;
        end
    end

    assign bus.gen_clear = clear_q;
    assign bus.gen_step  = step_q;
    assign bus.out_data  = data_q;
    assign bus.out_seq   = seq_q;
    assign bus.out_last  = last_q;
    assign bus.out_valid = (state == PRESENT);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
endmodule
